flash_sample_unpacker: RTL

//  Downstream consumer of the flash read master (fsm1). Requests 32-bit words from fsm1 and splits each

---
 rtl/speech_pkg.sv | 25 ++
 rtl/sample_lane_mux.sv | 30 +++
 rtl/flash_sample_unpacker.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/speech_pkg.sv
// speech_pkg
//  Shared definitions for the flash sample unpacker: default word/sample widths,
//  the default lane order and the fetch/emit state encodings.
package speech_pkg;

  localparam int DEF_WORD_W   = 32;
  localparam int DEF_SAMPLE_W = 8;
  localparam int DEF_CNT_W    = 16;

  // 1: the least significant lane of a word is played first.
  localparam bit LANE_ORDER_LSB_FIRST = 1'b1;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_FULL = 2'd2,
    F_END  = 2'd3
  } fetch_state_t;

  typedef enum logic {
    E_EMPTY = 1'b0,
    E_EMIT  = 1'b1
  } emit_state_t;

endpackage

// File: rtl/sample_lane_mux.sv
// sample_lane_mux
//  Combinational selection of one SAMPLE_W lane out of a WORD_W word.
//  Ports:
//    word    in   WORD_W    word being played
//    lane    in   LANE_W    play-order index of the wanted sample (0 = first played)
//    sample  out  SAMPLE_W  selected sample
module sample_lane_mux #(
  parameter int WORD_W    = 32,
  parameter int SAMPLE_W  = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int LANE_W    = 2
) (
  input  logic [WORD_W-1:0]   word,
  input  logic [LANE_W-1:0]   lane,
  output logic [SAMPLE_W-1:0] sample
);

  localparam int N = WORD_W / SAMPLE_W;

  logic [SAMPLE_W-1:0] lanes [N];

  // lanes[] is indexed by play order, so the lane order is resolved at elaboration.
  for (genvar g = 0; g < N; g++) begin : g_lane
    localparam int SRC = LSB_FIRST ? g : (N - 1 - g);
    assign lanes[g] = word[SRC*SAMPLE_W +: SAMPLE_W];
  end

  assign sample = lanes[lane];

endmodule

// File: rtl/flash_sample_unpacker.sv
// flash_sample_unpacker
//  Requests words from the flash read master, splits each word into
//  WORD_W/SAMPLE_W samples and streams them over a valid/ready handshake.
//  A one-word prefetch buffer (nxt_word) overlaps the next flash read with playback.
//  Ports:
//    clk, reset          clock (rising edge), asynchronous active-high reset
//    start, word_count   one-cycle start pulse and phrase length in words
//    rd_req              registered read request to the flash read master
//    rd_data, rd_done    returned word, valid in the rd_done cycle
//    smp_data, smp_valid sample stream to the audio stage
//    smp_ready           stream backpressure
//    busy, finished      phrase in progress / one-cycle completion pulse
module flash_sample_unpacker
  import speech_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter bit LSB_FIRST = LANE_ORDER_LSB_FIRST,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_W-1:0]    word_count,
  output logic                rd_req,
  input  logic [WORD_W-1:0]   rd_data,
  input  logic                rd_done,
  output logic [SAMPLE_W-1:0] smp_data,
  output logic                smp_valid,
  input  logic                smp_ready,
  output logic                busy,
  output logic                finished
);

  localparam int N      = WORD_W / SAMPLE_W;
  localparam int LANE_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N - 1);

  fetch_state_t f_state, f_next;
  emit_state_t  e_state, e_next;

  logic [CNT_W-1:0]    word_cnt_q;
  logic [CNT_W-1:0]    req_cnt;
  logic [CNT_W-1:0]    emit_cnt;
  logic [WORD_W-1:0]   nxt_word;
  logic                nxt_valid;
  logic [WORD_W-1:0]   cur_word;
  logic [LANE_W-1:0]   lane;
  logic [SAMPLE_W-1:0] lane_sample;
  logic                rd_req_next;

  logic start_ok;
  logic rd_accept;
  logic accept;
  logic last_lane;
  logic load_cur;
  logic phrase_done;

  assign start_ok    = start && !busy;
  // A late rd_done from a read abandoned by reset arrives with rd_req low and is dropped.
  assign rd_accept   = rd_done && rd_req && (f_state == F_REQ);
  assign smp_valid   = (e_state == E_EMIT);
  assign accept      = smp_valid && smp_ready;
  assign last_lane   = (lane == LAST_LANE);
  // The buffered word moves to cur_word either into an idle player or on the
  // final lane's accept, which keeps the stream gapless across words.
  assign load_cur    = nxt_valid && ((e_state == E_EMPTY) || (accept && last_lane));
  assign phrase_done = busy && (emit_cnt == word_cnt_q);

  sample_lane_mux #(
    .WORD_W    (WORD_W),
    .SAMPLE_W  (SAMPLE_W),
    .LSB_FIRST (LSB_FIRST),
    .LANE_W    (LANE_W)
  ) u_lane_mux (
    .word   (cur_word),
    .lane   (lane),
    .sample (lane_sample)
  );

  assign smp_data = smp_valid ? lane_sample : '0;

  always_comb begin
    f_next = f_state;
    case (f_state)
      F_IDLE: if (start_ok) f_next = (word_count == '0) ? F_END : F_REQ;
      F_REQ:  if (rd_accept) f_next = (CNT_W'(req_cnt + 1'b1) == word_cnt_q) ? F_END : F_FULL;
      // Leave as soon as the buffer drains (including the draining cycle itself)
      // so the next read is already in flight while the current word plays.
      F_FULL: if (!nxt_valid || load_cur) f_next = F_REQ;
      F_END:  if (phrase_done) f_next = F_IDLE;
      default: f_next = F_IDLE;
    endcase
    rd_req_next = (f_next == F_REQ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_state <= F_IDLE;
      rd_req  <= 1'b0;
    end else begin
      f_state <= f_next;
      rd_req  <= rd_req_next;
    end
  end

  always_comb begin
    e_next = e_state;
    case (e_state)
      E_EMPTY: if (nxt_valid) e_next = E_EMIT;
      E_EMIT:  if (accept && last_lane && !nxt_valid) e_next = E_EMPTY;
      default: e_next = E_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_state <= E_EMPTY;
    end else begin
      e_state <= e_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt_q <= '0;
      req_cnt    <= '0;
      emit_cnt   <= '0;
      busy       <= 1'b0;
      finished   <= 1'b0;
      nxt_word   <= '0;
      nxt_valid  <= 1'b0;
      cur_word   <= '0;
      lane       <= '0;
    end else begin
      if (start_ok) begin
        word_cnt_q <= word_count;
        req_cnt    <= '0;
        emit_cnt   <= '0;
        busy       <= 1'b1;
      end else if (phrase_done) begin
        busy <= 1'b0;
      end
      finished <= phrase_done;

      if (rd_accept) begin
        nxt_word <= rd_data;
        req_cnt  <= req_cnt + 1'b1;
      end

      // rd_req is never high while nxt_valid is set, so fill and drain cannot collide.
      if (load_cur) begin
        nxt_valid <= 1'b0;
      end else if (rd_accept) begin
        nxt_valid <= 1'b1;
      end

      if (load_cur) begin
        cur_word <= nxt_word;
        lane     <= '0;
      end else if (accept && !last_lane) begin
        lane <= lane + 1'b1;
      end

      if (accept && last_lane) begin
        emit_cnt <= emit_cnt + 1'b1;
      end
    end
  end

endmodule
